ft_small_fifo: RTL and testbench
================================

// Module: ft_small_fifo
// PURPOSE
// - First-word-fall-through FIFO buffering AXI-Stream beats {tlast,tuser,tkeep,tdata} between RX input and parser FSM.
// - Head word is always presented on dout while empty=0; rd_en pops it (no read latency).
// - nearly_full drives upstream tready; prog_full is available for watermark back-pressure.
// PARAMETERS
// - WIDTH               72                    data word width in bits
// - MAX_DEPTH_BITS      3                     log2 of capacity; DEPTH = 2**MAX_DEPTH_BITS words
// - PROG_FULL_THRESHOLD 2**MAX_DEPTH_BITS-1   occupancy at or above which prog_full asserts
// PORTS
// - clk          in   1      single clock; all logic on rising edge
// - resetn       in   1      asynchronous, active-low reset
// - din          in   WIDTH  write data
// - wr_en        in   1      write strobe
// - rd_en        in   1      pop head word
// - dout         out  WIDTH  head word, valid when empty=0
// - full         out  1      count == DEPTH
// - nearly_full  out  1      count >= DEPTH-1
// - prog_full    out  1      count >= PROG_FULL_THRESHOLD
// - empty        out  1      no word visible on dout
// BEHAVIOUR
// - Reset (async, resetn=0): count=0, pointers=0, empty=1, full=0, nearly_full=0, prog_full=0, dout=0.
// - count = words held, including the word on dout; range 0..DEPTH, width MAX_DEPTH_BITS+1.
// - Write accepted on an edge when wr_en=1 and full=0; a write while full is dropped, with no state change.
// - Read accepted on an edge when rd_en=1 and empty=0; a read while empty is ignored.
// - Latency: a word written into an empty FIFO at edge t appears on dout, with empty=0, after edge t+1.
// - Pop at edge t: dout shows the next word, or empty=1, immediately after edge t.
// - Zero-bubble streaming: with count>=2, consecutive rd_en cycles deliver a new word on every cycle.
// - Simultaneous accepted read+write: count unchanged and ordering preserved.
// - Simultaneous read+write on the last word: empty=1 for exactly one cycle, then the new word appears.
// - Flags are registered and derived from the next count:
//   - full, nearly_full and prog_full update on the same edge as the count change.
//   - nearly_full=1 also whenever full=1.
// - Pointers wrap modulo DEPTH; data order is strictly FIFO across wrap.
// - dout holds its value while rd_en=0; its value is don't-care while empty=1.
// CONFIGURATION
// - Macro FT_SMALL_FIFO_ASSERT_EN, when defined:
//   - Simulation checks $display an error with %m and time on write-when-full and on read-when-empty.
//   - Check logic is inside `ifdef, non-synthesizable.
// - Macro undefined: no checks, silent drop/ignore as above. Datapath identical in both builds.
// STRUCTURE
// - Shared package: clog2 helper function and the DEPTH/count-width localparam derivations.
// - Sub-module ft_small_fifo_ram: DEPTH x WIDTH register array with write and read ports.
// - Top level holds pointers, count, flags and the fall-through output register.
// TESTING
// - Checks are written for WIDTH=8, MAX_DEPTH_BITS=3 (DEPTH=8), PROG_FULL_THRESHOLD=6.
// - Reset: resetn=0 mid-stream with count=5 -> empty=1, full=0, nearly_full=0, prog_full=0; a following write of 0xA1 pops back 0xA1.
// - Fall-through: write 0x11 into empty FIFO at edge t.
//   - empty=0 and dout=0x11 after edge t+1.
//   - rd_en pulse -> empty=1 after the next edge.
// - Fill: write 0x00..0x07 with no reads.
//   - prog_full=1 at count 6, nearly_full=1 at count 7, full=1 at count 8.
//   - A 9th write of 0xFF is dropped; draining yields 0x00..0x07 in order.
// - Streaming: write 0x20..0x2F and read continuously with rd_en=1 whenever empty=0.
//   - All 16 words emerge in order across pointer wrap.
//   - No bubbles once count>=2.
// - Simultaneous: at count=4, wr_en=rd_en=1 for 3 cycles -> count stays 4; outputs are the head words in order.
// - Underflow: rd_en=1 with empty=1 -> no state change; with FT_SMALL_FIFO_ASSERT_EN an error message is printed.

Source files
------------

// File: rtl/ft_small_fifo_pkg.sv
// Shared constants and helpers for the first-word-fall-through FIFO.
package ft_small_fifo_pkg;

  localparam int FT_DEF_WIDTH      = 72;
  localparam int FT_DEF_DEPTH_BITS = 3;

  // Ceiling log2, usable in constant expressions for count/pointer widths.
  function automatic int clog2(input int value);
    int r;
    int v;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

  function automatic int depth_of(input int depth_bits);
    return 1 << depth_bits;
  endfunction

endpackage

// File: rtl/ft_small_fifo_ram.sv
// DEPTH x WIDTH register array: synchronous write port, combinational read port.
module ft_small_fifo_ram
  import ft_small_fifo_pkg::*;
#(
  parameter int WIDTH  = FT_DEF_WIDTH,
  parameter int ADDR_W = FT_DEF_DEPTH_BITS
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [WIDTH-1:0]  wdata,
  input  logic [ADDR_W-1:0] raddr,
  output logic [WIDTH-1:0]  rdata
);

  logic [WIDTH-1:0] mem [depth_of(ADDR_W)];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/ft_small_fifo.sv
// First-word-fall-through FIFO: RAM behind a registered head word on dout.
// Define FT_SMALL_FIFO_ASSERT_EN for simulation messages on write-when-full / read-when-empty.
module ft_small_fifo
  import ft_small_fifo_pkg::*;
#(
  parameter int WIDTH               = FT_DEF_WIDTH,
  parameter int MAX_DEPTH_BITS      = FT_DEF_DEPTH_BITS,
  parameter int PROG_FULL_THRESHOLD = depth_of(MAX_DEPTH_BITS) - 1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic [WIDTH-1:0] din,
  input  logic             wr_en,
  input  logic             rd_en,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             nearly_full,
  output logic             prog_full,
  output logic             empty
);

  localparam int DEPTH = depth_of(MAX_DEPTH_BITS);
  localparam int CNT_W = clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] NFULL_C = CNT_W'(DEPTH - 1);
  localparam logic [CNT_W-1:0] PFULL_C = CNT_W'(PROG_FULL_THRESHOLD);

  logic [MAX_DEPTH_BITS-1:0] wr_ptr;
  logic [MAX_DEPTH_BITS-1:0] rd_ptr;
  logic [CNT_W-1:0]          count;
  logic [CNT_W-1:0]          count_nxt;
  logic [CNT_W-1:0]          ram_cnt;
  logic [WIDTH-1:0]          ram_rdata;
  logic                      head_valid;
  logic                      wr_acc;
  logic                      rd_acc;
  logic                      load_head;

  // count covers the head register too; ram_cnt is what still sits in the array.
  always_comb begin
    wr_acc    = wr_en & ~full;
    rd_acc    = rd_en & head_valid;
    ram_cnt   = count - CNT_W'(head_valid);
    load_head = (ram_cnt != '0) && (!head_valid || rd_acc);
    count_nxt = count + CNT_W'(wr_acc) - CNT_W'(rd_acc);
  end

  ft_small_fifo_ram #(
    .WIDTH  (WIDTH),
    .ADDR_W (MAX_DEPTH_BITS)
  ) u_ram (
    .clk   (clk),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      count       <= '0;
      head_valid  <= 1'b0;
      dout        <= '0;
      full        <= 1'b0;
      nearly_full <= 1'b0;
      prog_full   <= 1'b0;
    end else begin
      count       <= count_nxt;
      full        <= (count_nxt == DEPTH_C);
      nearly_full <= (count_nxt >= NFULL_C);
      prog_full   <= (count_nxt >= PFULL_C);
      if (wr_acc) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      // A word written on this edge is not yet counted in ram_cnt, which
      // gives the one-cycle fall-through latency into an empty FIFO.
      if (load_head) begin
        dout       <= ram_rdata;
        rd_ptr     <= rd_ptr + 1'b1;
        head_valid <= 1'b1;
      end else if (rd_acc) begin
        head_valid <= 1'b0;
      end
    end
  end

  assign empty = ~head_valid;

`ifdef FT_SMALL_FIFO_ASSERT_EN
  always @(posedge clk) begin
    if (resetn && wr_en && full) begin
      $display("ERROR: %m write while full at time %0t", $time);
    end
    if (resetn && rd_en && empty) begin
      $display("ERROR: %m read while empty at time %0t", $time);
    end
  end
`endif

endmodule

// File: tb/tb_ft_small_fifo.sv
// Scoreboard bench for ft_small_fifo (WIDTH=8, DEPTH=8, prog_full threshold 6).
module tb_ft_small_fifo;

  localparam int W     = 8;
  localparam int DEPTH = 8;
  localparam int PFT   = 6;

  logic         clk = 1'b0;
  logic         resetn = 1'b1;
  logic [W-1:0] din = '0;
  logic         wr_en = 1'b0;
  logic         rd_en = 1'b0;
  logic [W-1:0] dout;
  logic         full;
  logic         nearly_full;
  logic         prog_full;
  logic         empty;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  // Reference model: words held, plus the edge number each was written on.
  logic [W-1:0] exp_q[$];
  int           wt_q[$];

  always #5 clk = ~clk;

  ft_small_fifo #(
    .WIDTH               (W),
    .MAX_DEPTH_BITS      (3),
    .PROG_FULL_THRESHOLD (PFT)
  ) dut (
    .clk         (clk),
    .resetn      (resetn),
    .din         (din),
    .wr_en       (wr_en),
    .rd_en       (rd_en),
    .dout        (dout),
    .full        (full),
    .nearly_full (nearly_full),
    .prog_full   (prog_full),
    .empty       (empty)
  );

  task automatic check_val(input string name, input logic [W-1:0] act, input logic [W-1:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
    end
  endtask

  task automatic check_bit(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, expv, $time);
    end
  endtask

  // Head is visible once it has been stored for at least one full edge.
  function automatic bit model_visible();
    return (exp_q.size() > 0) && (wt_q[0] < cyc);
  endfunction

  // Model update on each clock edge (or async reset).
  initial begin
    bit m_rd;
    bit m_wr;
    forever begin
      @(posedge clk or negedge resetn);
      if (!resetn) begin
        exp_q.delete();
        wt_q.delete();
      end else begin
        m_rd = rd_en && model_visible();
        m_wr = wr_en && (exp_q.size() < DEPTH);
        cyc++;
        if (m_rd) begin
          void'(exp_q.pop_front());
          void'(wt_q.pop_front());
        end
        if (m_wr) begin
          exp_q.push_back(din);
          wt_q.push_back(cyc);
        end
      end
    end
  end

  // Monitor: compares DUT outputs against the model on every falling edge.
  initial begin
    int sz;
    forever begin
      @(negedge clk);
      if (!resetn) begin
        check_bit("rst_empty", empty, 1'b1);
        check_bit("rst_full", full, 1'b0);
        check_bit("rst_nearly_full", nearly_full, 1'b0);
        check_bit("rst_prog_full", prog_full, 1'b0);
        check_val("rst_dout", dout, '0);
      end else begin
        sz = exp_q.size();
        check_bit("empty", empty, !model_visible());
        check_bit("full", full, sz == DEPTH);
        check_bit("nearly_full", nearly_full, sz >= DEPTH - 1);
        check_bit("prog_full", prog_full, sz >= PFT);
        if (model_visible()) begin
          check_val("dout", dout, exp_q[0]);
        end
      end
    end
  end

  task automatic step(input logic w, input logic [W-1:0] d, input logic r);
    wr_en = w;
    din   = d;
    rd_en = r;
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int g;
    g = 0;
    step(1'b0, '0, 1'b0);
    while (!empty && g < 40) begin
      step(1'b0, '0, 1'b1);
      g++;
    end
    step(1'b0, '0, 1'b0);
    check_bit("drain_empty", empty, 1'b1);
  endtask

  initial begin
    int n;
    int guard;
    logic [W-1:0] v;

    #1 resetn = 1'b0;
    @(posedge clk); #1;
    @(posedge clk); #1;
    resetn = 1'b1;

    // Fall-through latency into an empty FIFO.
    step(1'b1, 8'h11, 1'b0);
    check_bit("ft_empty_after_t", empty, 1'b1);
    step(1'b0, '0, 1'b0);
    check_bit("ft_empty_after_t1", empty, 1'b0);
    check_val("ft_dout", dout, 8'h11);
    step(1'b0, '0, 1'b1);
    check_bit("ft_pop_empty", empty, 1'b1);

    // Fill to capacity, then an overflowing write.
    for (int i = 0; i < DEPTH; i++) begin
      step(1'b1, W'(i), 1'b0);
      check_bit("fill_prog_full", prog_full, (i + 1) >= PFT);
      check_bit("fill_nearly_full", nearly_full, (i + 1) >= DEPTH - 1);
      check_bit("fill_full", full, (i + 1) == DEPTH);
    end
    step(1'b1, 8'hFF, 1'b0);
    check_bit("overflow_full", full, 1'b1);
    for (int i = 0; i < DEPTH; i++) begin
      check_val("fill_drain", dout, W'(i));
      step(1'b0, '0, 1'b1);
    end
    check_bit("fill_drained", empty, 1'b1);

    // Streaming across pointer wrap.
    n = 0;
    guard = 0;
    while ((n < 16 || !empty) && guard < 100) begin
      step(n < 16, W'(8'h20 + n), !empty);
      if (n < 16) n++;
      guard++;
    end
    checks++;
    if (guard >= 100) begin
      errors++;
      $display("FAIL stream_timeout: got %0d cycles expected < 100", guard);
    end
    drain();

    // Simultaneous read+write at count 4.
    for (int i = 0; i < 4; i++) step(1'b1, W'($urandom), 1'b0);
    step(1'b0, '0, 1'b0);
    for (int i = 0; i < 3; i++) step(1'b1, W'($urandom), 1'b1);
    check_bit("simul_prog_full", prog_full, 1'b0);
    drain();

    // Simultaneous read+write on the last word: one-cycle empty gap.
    step(1'b1, 8'h55, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 8'h66, 1'b1);
    check_bit("last_word_gap", empty, 1'b1);
    step(1'b0, '0, 1'b0);
    check_bit("last_word_refill", empty, 1'b0);
    check_val("last_word_dout", dout, 8'h66);
    drain();

    // Underflow: reads while empty change nothing.
    for (int i = 0; i < 3; i++) step(1'b0, '0, 1'b1);
    check_bit("underflow_empty", empty, 1'b1);

    // Randomized traffic biased to reach full.
    for (int i = 0; i < 400; i++) begin
      v = W'($urandom);
      step($urandom_range(0, 9) < 6, v, $urandom_range(0, 9) < 5);
    end
    drain();

    // Reset mid-stream with count 5.
    for (int i = 0; i < 5; i++) step(1'b1, W'(8'h40 + i), 1'b0);
    resetn = 1'b0;
    #2;
    check_bit("midrst_empty", empty, 1'b1);
    check_bit("midrst_full", full, 1'b0);
    check_bit("midrst_nearly_full", nearly_full, 1'b0);
    check_bit("midrst_prog_full", prog_full, 1'b0);
    @(posedge clk); #1;
    resetn = 1'b1;
    step(1'b1, 8'hA1, 1'b0);
    step(1'b0, '0, 1'b0);
    check_val("post_rst_dout", dout, 8'hA1);
    step(1'b0, '0, 1'b1);
    check_bit("post_rst_empty", empty, 1'b1);
    step(1'b0, '0, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
